// File: rtl/daw_audio_pkg.sv
// -----------------------------------------------------------------------------
// daw_audio_pkg
// Shared definitions for the audio playback path:
//   - fetch_state_t : state encoding of the sample-fetch FSM
//   - DEFAULT_DIV   : system clocks per audio sample (100 MHz / 44.1 kHz)
//   - DAC_OFFSET    : offset that maps signed PCM onto an unsigned DAC code
//   - to_dac()      : signed sample MSB byte -> unsigned DAC code
// -----------------------------------------------------------------------------
package daw_audio_pkg;

   localparam int unsigned DEFAULT_DIV = 2268;
   localparam logic [7:0]  DAC_OFFSET  = 8'h80;

   typedef enum logic [2:0] {
      IDLE,
      REQ_LO,
      WAIT_LO,
      REQ_HI,
      WAIT_HI,
      PUSH
   } fetch_state_t;

   // Flipping the sign bit turns two's complement into offset binary.
   function automatic logic [7:0] to_dac(input logic [7:0] msb);
      return msb ^ DAC_OFFSET;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous 16-bit FIFO holding assembled PCM samples between the byte
// fetcher and the sample-rate output stage. Show-ahead: rdata is the head entry.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write one entry (ignored when full unless popping too)
//   pop        : drop the head entry (ignored when empty)
//   rdata      : current head entry
//   full/empty : occupancy flags
//   level      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sample_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [15:0]            wdata,
   input  logic                   pop,
   output logic [15:0]            rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a
   // push that coincides with a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full  = (level == FULL_LEVEL);
   assign empty = (level == '0);
   assign rdata = mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; level and pointers
   // define which entries are valid, so stale data is never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/sample_streamer.sv
// -----------------------------------------------------------------------------
// sample_streamer
// Pulls little-endian 16-bit PCM samples byte by byte from the SD read FIFO,
// buffers them, and releases one sample every DIV system clocks.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   enable        : 1 = fetch and play; 0 = stop fetching and stop ticks
//   src_empty     : SD read FIFO has no bytes
//   rd_en         : one-cycle pop strobe to the SD read FIFO
//   rd_dat        : SD FIFO byte, valid the cycle after rd_en
//   sample        : current signed PCM sample
//   dac_val       : unsigned DAC code derived from sample[15:8]
//   sample_tick   : one-cycle pulse when sample updates
//   buf_level     : samples currently buffered
//   underrun_cnt  : saturating count of ticks that found the buffer empty
// -----------------------------------------------------------------------------
module sample_streamer
   import daw_audio_pkg::*;
#(
   parameter int unsigned DIV   = DEFAULT_DIV,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   src_empty,
   output logic                   rd_en,
   input  logic [7:0]             rd_dat,
   output logic [15:0]            sample,
   output logic [7:0]             dac_val,
   output logic                   sample_tick,
   output logic [$clog2(DEPTH):0] buf_level,
   output logic [7:0]             underrun_cnt
);

   localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   fetch_state_t  state;
   fetch_state_t  state_nx;
   logic          rd_q;
   logic [7:0]    lo_byte;
   logic [7:0]    hi_byte;
   logic          push;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [15:0]   fifo_head;
   logic [CW-1:0] tick_cnt;
   logic          tick;

   // ---------------------------------------------------------------- fetch FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      rd_en    = 1'b0;
      push     = 1'b0;
      case (state)
         // Only IDLE looks at enable: once a sample is half fetched it always
         // completes, keeping byte alignment with the source.
         IDLE:    if (enable && !fifo_full && !src_empty) state_nx = REQ_LO;
         REQ_LO:  if (!src_empty) begin
                     rd_en    = 1'b1;
                     state_nx = WAIT_LO;
                  end
         WAIT_LO: if (!src_empty) state_nx = REQ_HI;
         REQ_HI:  if (!src_empty) begin
                     rd_en    = 1'b1;
                     state_nx = WAIT_HI;
                  end
         WAIT_HI: state_nx = PUSH;
         PUSH:    begin
                     push     = 1'b1;
                     state_nx = IDLE;
                  end
         default: state_nx = IDLE;
      endcase
   end

   // rd_dat is valid only in the cycle right after the strobe, which is the
   // first cycle spent in the matching WAIT state; rd_q marks that cycle so a
   // long stay in WAIT_LO does not re-capture a stale byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q    <= 1'b0;
         lo_byte <= '0;
         hi_byte <= '0;
      end else begin
         rd_q <= rd_en;
         if (rd_q && state == WAIT_LO) lo_byte <= rd_dat;
         if (rd_q && state == WAIT_HI) hi_byte <= rd_dat;
      end
   end

   sample_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({hi_byte, lo_byte}),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (buf_level)
   );

   // -------------------------------------------------------------- sample rate
   // The tick is the wrap from DIV-1 back to 0, so it fires once per DIV
   // enabled cycles and never while enable is low.
   assign tick     = enable && (tick_cnt == LAST);
   assign fifo_pop = tick && !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      tick_cnt <= '0;
      else if (!enable) tick_cnt <= '0;
      else if (tick)    tick_cnt <= '0;
      else              tick_cnt <= tick_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample       <= '0;
         sample_tick  <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         sample_tick <= fifo_pop;
         if (fifo_pop) sample <= fifo_head;
         if (tick && fifo_empty && underrun_cnt != 8'hFF)
            underrun_cnt <= underrun_cnt + 1'b1;
      end
   end

   assign dac_val = to_dac(sample[15:8]);

endmodule
